// File: rtl/bit_reorder_pkg.sv
// Shared types and helpers for the ping-pong bit/digit reorder buffer.
package bit_reorder_pkg;

  localparam logic MODE_BITREV  = 1'b0;
  localparam logic MODE_DIGREV4 = 1'b1;

  // Wide enough for any stored log2 length up to 31.
  localparam int LOG_W = 5;

  typedef struct packed {
    logic [LOG_W-1:0] log_len;
    logic             mode;
  } cfg_t;

  function automatic int clamp_log(input int lg, input int lo, input int hi);
    if (lg < lo) return lo;
    if (lg > hi) return hi;
    return lg;
  endfunction

endpackage

// File: rtl/reorder_addr_perm.sv
// Combinational read-address permutation: radix-2 bit reversal or radix-4
// digit reversal of the low log_len bits of the counter.
module reorder_addr_perm
  import bit_reorder_pkg::*;
#(
  parameter int LOG_MAX = 10
) (
  input  logic [LOG_MAX-1:0] cnt,
  input  logic [LOG_W-1:0]   log_len,
  input  logic               mode,
  output logic [LOG_MAX-1:0] addr
);

  localparam int IW = (LOG_MAX > 1) ? $clog2(LOG_MAX) : 1;

  always_comb begin
    int lg;
    int src;
    addr = '0;
    lg   = int'(log_len);
    src  = 0;
    for (int i = 0; i < LOG_MAX; i++) begin
      if (i < lg) begin
        // Digit mode keeps the bit order inside each base-4 digit.
        if (mode == MODE_DIGREV4) src = (lg / 2 - 1 - i / 2) * 2 + (i % 2);
        else                      src = lg - 1 - i;
        addr[i] = cnt[src[IW-1:0]];
      end
    end
  end

endmodule

// File: rtl/bit_reorder_pp.sv
// Ping-pong reorder buffer: writes FFT output in arrival order into one bank
// while the other bank is read back in natural order through a 2-entry skid.
module bit_reorder_pp
  import bit_reorder_pkg::*;
#(
  parameter int DATA_W  = 20,
  parameter int LOG_MAX = 10,
  parameter int LOG_MIN = 2
) (
  input  logic                         mclk,
  input  logic                         i_rst,
  input  logic                         i_init,
  input  logic [$clog2(LOG_MAX+1)-1:0] i_log_len,
  input  logic                         i_mode,
  input  logic                         i_vld,
  output logic                         o_rdy,
  input  logic [DATA_W-1:0]            i_data,
  output logic                         o_vld,
  input  logic                         i_rdy,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_new_fft,
  output logic                         o_last,
  output logic                         o_cfg_err
);

  localparam int DEPTH = 2 ** LOG_MAX;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } ent_t;

  function automatic logic [LOG_MAX-1:0] last_idx(input logic [LOG_W-1:0] lg);
    logic [LOG_MAX-1:0] ones;
    ones = '1;
    return ones >> (LOG_MAX - int'(lg));
  endfunction

  logic [DATA_W-1:0]  mem [2*DEPTH];

  logic               wr_bank, wr_bank_n;
  logic [LOG_MAX-1:0] wr_cnt, wr_cnt_n;
  logic               rd_bank, rd_bank_n;
  logic [LOG_MAX-1:0] rd_cnt, rd_cnt_n, rd_addr;
  logic [1:0]         full, full_n;
  cfg_t               cfg_r [2];
  cfg_t               cfg_n [2];
  cfg_t               cfg_in, wr_cfg, rd_cfg;
  logic               cfg_bad;

  logic               wr_en, wr_start, wr_done;
  logic               issue, rd_last;
  logic               rdy_n, err_n;

  logic               vld_p1, first_p1, last_p1;
  logic               vld_p1_n, first_p1_n, last_p1_n;
  logic [DATA_W-1:0]  data_p1;
  ent_t               ent_p1;

  logic [1:0]         occ, occ_n;
  logic [2:0]         occ_after;
  ent_t               e0, e1, e0_n, e1_n;
  logic               pop, push;

  // Frame configuration as it will be latched on a frame-start accept.
  always_comb begin
    int req;
    int adj;
    req            = int'(i_log_len);
    adj            = clamp_log(req, LOG_MIN, LOG_MAX);
    cfg_in.log_len = LOG_W'(adj);
    cfg_in.mode    = ((i_mode == MODE_DIGREV4) && (adj % 2 == 0)) ? MODE_DIGREV4 : MODE_BITREV;
    cfg_bad        = (adj != req) || ((i_mode == MODE_DIGREV4) && (adj % 2 != 0));
  end

  assign wr_en    = i_vld & o_rdy;
  assign wr_start = wr_en & (wr_cnt == '0);
  assign wr_cfg   = (wr_cnt == '0) ? cfg_in : cfg_r[wr_bank];
  assign wr_done  = wr_en & (wr_cnt == last_idx(wr_cfg.log_len));

  assign rd_cfg   = cfg_r[rd_bank];
  assign rd_last  = (rd_cnt == last_idx(rd_cfg.log_len));

  reorder_addr_perm #(.LOG_MAX(LOG_MAX)) u_perm (
    .cnt     (rd_cnt),
    .log_len (rd_cfg.log_len),
    .mode    (rd_cfg.mode),
    .addr    (rd_addr)
  );

  // Issue only if the skid can still hold this read plus whatever is in flight.
  assign pop       = (occ != 2'd0) & i_rdy;
  assign push      = vld_p1;
  assign occ_after = 3'(occ) + 3'(vld_p1) - 3'(pop);
  assign issue     = full[rd_bank] & (occ_after <= 3'd1);
  assign ent_p1    = {data_p1, first_p1, last_p1};

  always_comb begin
    wr_bank_n  = wr_bank;
    wr_cnt_n   = wr_cnt;
    rd_bank_n  = rd_bank;
    rd_cnt_n   = rd_cnt;
    full_n     = full;
    cfg_n[0]   = cfg_r[0];
    cfg_n[1]   = cfg_r[1];
    vld_p1_n   = issue;
    first_p1_n = issue & (rd_cnt == '0);
    last_p1_n  = issue & rd_last;
    err_n      = wr_start & cfg_bad;
    occ_n      = occ;
    e0_n       = e0;
    e1_n       = e1;

    if (wr_en) begin
      if (wr_start) cfg_n[wr_bank] = cfg_in;
      if (wr_done) begin
        full_n[wr_bank] = 1'b1;
        wr_bank_n       = ~wr_bank;
        wr_cnt_n        = '0;
      end else begin
        wr_cnt_n = wr_cnt + LOG_MAX'(1);
      end
    end

    if (issue) begin
      if (rd_last) begin
        full_n[rd_bank] = 1'b0;
        rd_bank_n       = ~rd_bank;
        rd_cnt_n        = '0;
      end else begin
        rd_cnt_n = rd_cnt + LOG_MAX'(1);
      end
    end

    case ({push, pop})
      2'b10: begin
        if (occ == 2'd0) e0_n = ent_p1;
        else             e1_n = ent_p1;
        occ_n = occ + 2'd1;
      end
      2'b01: begin
        e0_n  = e1;
        occ_n = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) e0_n = ent_p1;
        else begin
          e0_n = e1;
          e1_n = ent_p1;
        end
      end
      default: ;
    endcase

    rdy_n = ~full_n[wr_bank_n];

    if (i_init) begin
      wr_bank_n  = 1'b0;
      wr_cnt_n   = '0;
      rd_bank_n  = 1'b0;
      rd_cnt_n   = '0;
      full_n     = 2'b00;
      cfg_n[0]   = '0;
      cfg_n[1]   = '0;
      vld_p1_n   = 1'b0;
      first_p1_n = 1'b0;
      last_p1_n  = 1'b0;
      err_n      = 1'b0;
      occ_n      = 2'd0;
      e0_n       = '0;
      e1_n       = '0;
      rdy_n      = 1'b1;
    end
  end

  // Stage p0 -> p1: bank write and registered bank read.
  always_ff @(posedge mclk) begin
    if (wr_en) mem[{wr_bank, wr_cnt}] <= i_data;
    if (issue) data_p1 <= mem[{rd_bank, rd_addr}];
  end

  always_ff @(posedge mclk or posedge i_rst) begin
    if (i_rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      full      <= 2'b00;
      cfg_r[0]  <= '0;
      cfg_r[1]  <= '0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      o_cfg_err <= 1'b0;
      occ       <= 2'd0;
      e0        <= '0;
      e1        <= '0;
      o_rdy     <= 1'b1;
    end else begin
      wr_bank   <= wr_bank_n;
      wr_cnt    <= wr_cnt_n;
      rd_bank   <= rd_bank_n;
      rd_cnt    <= rd_cnt_n;
      full      <= full_n;
      cfg_r[0]  <= cfg_n[0];
      cfg_r[1]  <= cfg_n[1];
      vld_p1    <= vld_p1_n;
      first_p1  <= first_p1_n;
      last_p1   <= last_p1_n;
      o_cfg_err <= err_n;
      occ       <= occ_n;
      e0        <= e0_n;
      e1        <= e1_n;
      o_rdy     <= rdy_n;
    end
  end

  // Stage p1 -> skid head drives the output port.
  assign o_vld     = (occ != 2'd0);
  assign o_data    = e0.data;
  assign o_new_fft = o_vld & e0.first;
  assign o_last    = o_vld & e0.last;

endmodule

// File: tb/tb_bit_reorder_pp.sv
// Directed bench for bit_reorder_pp: natural-order reconstruction, flags,
// latency, backpressure, config adjustment and reset/flush behaviour.
module tb_bit_reorder_pp;

  localparam int DATA_W  = 20;
  localparam int LOG_MAX = 10;
  localparam int LOG_MIN = 2;
  localparam int LW      = 4;

  logic              mclk, i_rst, i_init, i_mode, i_vld, o_rdy;
  logic              o_vld, i_rdy, o_new_fft, o_last, o_cfg_err;
  logic [LW-1:0]     i_log_len;
  logic [DATA_W-1:0] i_data, o_data;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              f;
    logic              l;
    int                t;
  } rec_t;

  rec_t q[$];
  int   exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   err_cnt   = 0;
  int   rdy_drops = 0;
  int   rdy_mode  = 0;
  int   e_base;

  bit_reorder_pp #(.DATA_W(DATA_W), .LOG_MAX(LOG_MAX), .LOG_MIN(LOG_MIN)) dut (
    .mclk      (mclk),
    .i_rst     (i_rst),
    .i_init    (i_init),
    .i_log_len (i_log_len),
    .i_mode    (i_mode),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_data    (i_data),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_data    (o_data),
    .o_new_fft (o_new_fft),
    .o_last    (o_last),
    .o_cfg_err (o_cfg_err)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial forever begin
    @(posedge mclk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: 0 = always, 1 = pseudo-random, 2 = never.
  initial begin
    i_rdy = 1'b1;
    forever begin
      @(posedge mclk);
      #1;
      case (rdy_mode)
        1:       i_rdy = ($urandom_range(0, 1) == 1);
        2:       i_rdy = 1'b0;
        default: i_rdy = 1'b1;
      endcase
    end
  end

  // Output collector and hold-under-stall checker.
  initial begin
    logic                prev_stall;
    logic [DATA_W+1:0]   prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge mclk);
      if (o_cfg_err) err_cnt++;
      if (rdy_mode == 1 && prev_stall) begin
        chk("hold_vld", 32'(o_vld), 32'd1);
        chk("hold_out", 32'({o_data, o_new_fft, o_last}), 32'(prev_out));
      end
      prev_stall = o_vld & ~i_rdy;
      prev_out   = {o_data, o_new_fft, o_last};
      if (o_vld && i_rdy) q.push_back('{d: o_data, f: o_new_fft, l: o_last, t: cyc});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic send(input int n, input int lg, input logic md, input int base);
    logic got;
    int   tmo;
    for (int i = 0; i < n; i++) begin
      i_vld     = 1'b1;
      i_data    = DATA_W'(base + i);
      i_log_len = LW'(lg);
      i_mode    = md;
      tmo       = 0;
      do begin
        got = o_rdy;
        tick(1);
        if (!got) begin
          rdy_drops++;
          tmo++;
        end
      end while (!got && tmo < 3000);
      if (!got) chk("send_timeout", 32'(tmo), 32'd0);
    end
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 4000) begin
      tick(1);
      t++;
    end
    chk("wait_outs", 32'(q.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag, input int base);
    rec_t r;
    int   n;
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      if (q.size() == 0) begin
        chk({tag, "_missing"}, 32'(j), 32'(n));
        break;
      end
      r = q.pop_front();
      chk($sformatf("%s_d%0d", tag, j), 32'(r.d), 32'(base + exp_q[j]));
      chk($sformatf("%s_f%0d", tag, j), 32'(r.f), 32'(j == 0));
      chk($sformatf("%s_l%0d", tag, j), 32'(r.l), 32'(j == n - 1));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst     = 1'b1;
    i_init    = 1'b0;
    i_vld     = 1'b0;
    i_data    = '0;
    i_log_len = '0;
    i_mode    = 1'b0;
    tick(3);
    chk("rst_vld",  32'(o_vld),     32'd0);
    chk("rst_rdy",  32'(o_rdy),     32'd1);
    chk("rst_data", 32'(o_data),    32'd0);
    chk("rst_new",  32'(o_new_fft), 32'd0);
    chk("rst_last", 32'(o_last),    32'd0);
    chk("rst_err",  32'(o_cfg_err), 32'd0);
    i_rst = 1'b0;
    tick(2);

    // LOG=3 bit reversal with latency check
    exp_q = '{0, 4, 2, 6, 1, 5, 3, 7};
    send(8, 3, 1'b0, 0);
    i_vld = 1'b0;
    tick(1);
    chk("t1_lat1", 32'(o_vld), 32'd0);
    tick(1);
    chk("t1_lat2", 32'(o_vld), 32'd1);
    wait_outs(8);
    check_frame("t1", 0);
    chk("t1_err", 32'(err_cnt), 32'd0);

    // LOG=4 radix-4 digit reversal
    e_base = err_cnt;
    exp_q  = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    send(16, 4, 1'b1, 'h100);
    i_vld = 1'b0;
    wait_outs(16);
    check_frame("t2", 'h100);
    chk("t2_err", 32'(err_cnt - e_base), 32'd0);

    // Three back-to-back LOG=3 frames
    rdy_drops = 0;
    send(8, 3, 1'b0, 'h200);
    send(8, 3, 1'b0, 'h300);
    send(8, 3, 1'b0, 'h400);
    i_vld = 1'b0;
    chk("t3_rdy_drops", 32'(rdy_drops), 32'd0);
    wait_outs(24);
    for (int k = 1; k < 24; k++)
      chk($sformatf("t3_gap%0d", k), 32'(q[k].t - q[k-1].t), 32'd1);
    exp_q = '{0, 4, 2, 6, 1, 5, 3, 7};
    check_frame("t3a", 'h200);
    check_frame("t3b", 'h300);
    check_frame("t3c", 'h400);

    // Backpressure: fill both banks, then drain under random ready
    rdy_mode = 2;
    tick(1);
    send(16, 4, 1'b0, 'h500);
    send(16, 4, 1'b0, 'h600);
    i_vld = 1'b0;
    tick(3);
    chk("t4_rdy_low", 32'(o_rdy), 32'd0);
    rdy_mode = 1;
    wait_outs(32);
    rdy_mode = 0;
    exp_q = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    check_frame("t4a", 'h500);
    check_frame("t4b", 'h600);

    // Odd length with digit mode falls back to bit reversal
    e_base = err_cnt;
    exp_q  = '{0, 4, 2, 6, 1, 5, 3, 7};
    send(8, 3, 1'b1, 'h700);
    i_vld = 1'b0;
    wait_outs(8);
    check_frame("t5a", 'h700);
    chk("t5a_err", 32'(err_cnt - e_base), 32'd1);

    // Oversized length clamps to 1024 samples
    e_base = err_cnt;
    send(1024, 15, 1'b0, 0);
    i_vld = 1'b0;
    wait_outs(1024);
    chk("t5b_d1",    32'(q[1].d),    32'd512);
    chk("t5b_d2",    32'(q[2].d),    32'd256);
    chk("t5b_d3",    32'(q[3].d),    32'd768);
    chk("t5b_d1023", 32'(q[1023].d), 32'd1023);
    chk("t5b_f0",    32'(q[0].f),    32'd1);
    chk("t5b_l1022", 32'(q[1022].l), 32'd0);
    chk("t5b_l1023", 32'(q[1023].l), 32'd1);
    chk("t5b_err",   32'(err_cnt - e_base), 32'd1);
    q.delete();

    // Asynchronous reset with output pending and a partial frame
    rdy_mode = 2;
    tick(1);
    send(8, 3, 1'b0, 'h800);
    send(5, 3, 1'b0, 'h900);
    i_vld = 1'b0;
    tick(3);
    chk("t6_pre_vld", 32'(o_vld), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(o_vld), 32'd0);
    chk("t6_rst_rdy", 32'(o_rdy), 32'd1);
    tick(1);
    i_rst    = 1'b0;
    rdy_mode = 0;
    tick(2);
    q.delete();
    exp_q = '{0, 4, 2, 6, 1, 5, 3, 7};
    send(8, 3, 1'b0, 'ha00);
    i_vld = 1'b0;
    wait_outs(8);
    check_frame("t6", 'ha00);
    tick(20);
    chk("t6_no_stale", 32'(q.size()), 32'd0);

    // Synchronous flush with output pending
    rdy_mode = 2;
    tick(1);
    send(8, 3, 1'b0, 'hb00);
    i_vld = 1'b0;
    tick(3);
    chk("init_pre_vld", 32'(o_vld), 32'd1);
    i_init = 1'b1;
    tick(1);
    i_init = 1'b0;
    chk("init_vld", 32'(o_vld), 32'd0);
    chk("init_rdy", 32'(o_rdy), 32'd1);
    rdy_mode = 0;
    tick(20);
    chk("init_no_out", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
